enc_out_arbiter: RTL
====================

Name: enc_out_arbiter

Overview:
Round-robin arbiter that shares the single 1024-bit encoded-output FIFO write port between N_ENG parallel macroblock encoder engines.
- Each engine emits one 7-beat result burst per macroblock: 4 beats ac_levels, 2 beats uv_levels, 1 beat side info.
- Bursts are granted whole and never interleaved.
- The arbiter sits between the engines and the host output FIFO and applies the FIFO's backpressure to the granted engine.

Parameters:
N_ENG, 2, number of requesting engines (2..8)
DATA_W, 1024, beat width in bits
BURST_LEN, 7, expected beats per macroblock burst
SRC_W, 1, width of source id; 2**SRC_W >= N_ENG

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
clear  input  1  synchronous frame restart (encoder start pulse)
eng_valid  input  N_ENG  per-engine beat valid
eng_last  input  N_ENG  per-engine final beat of burst
eng_data  input  N_ENG*DATA_W  per-engine beat data; engine i occupies [i*DATA_W +: DATA_W]
eng_ready  output  N_ENG  per-engine beat accept
fifo_full  input  1  output FIFO programmable-full, asserted with at least 2 free entries remaining
out_wr  output  1  output FIFO write strobe
out_data  output  DATA_W  output FIFO write data
out_src  output  SRC_W  engine id of current out_data
out_last  output  1  marks final beat of a forwarded burst
busy  output  1  high while in BURST
mb_count  output  16  bursts forwarded since clear
len_err  output  1  sticky burst-length violation

Behaviour:
- Reset (async, rst_n low): state IDLE, grant=0, last_grant=N_ENG-1, beat_cnt=0.
- Reset values of outputs: out_wr=0, out_data=0, out_src=0, out_last=0, mb_count=0, len_err=0, busy=0, eng_ready=0.
- A reset mid-burst abandons the burst. No partial recovery.
- clear (synchronous, priority over all else): same register values as reset.
- States: IDLE, BURST.
- IDLE:
  - If any eng_valid bit is set, select the first requesting engine searching from last_grant+1 upward, modulo N_ENG.
  - Register it as grant, clear beat_cnt, go to BURST.
  - No beat is accepted in IDLE, so there is a one-cycle bubble per burst.
- BURST:
  - eng_ready[i] = (i==grant) & ~fifo_full. This is combinational; all other eng_ready bits are 0.
  - accept = eng_valid[grant] & eng_ready[grant].
  - Grant is held through gaps in eng_valid[grant]. Other requesters are ignored until the burst ends.
- On accept:
  - Next cycle: out_wr=1, out_data=eng_data[grant], out_src=grant.
  - out_last=1 if this beat ends the burst.
  - beat_cnt increments.
  - out_wr is 0 on every cycle with no accept, so latency is exactly 1 cycle.
- Burst end, on an accepted beat where eng_last[grant]=1 OR beat_cnt==BURST_LEN-1:
  - Set last_grant=grant, increment mb_count (wraps at 65535→0), go to IDLE.
- len_err (sticky until reset/clear) is set on:
  - eng_last with beat_cnt != BURST_LEN-1, or
  - beat_cnt==BURST_LEN-1 accepted without eng_last.
  - The burst still terminates at that beat.
- fifo_full asserted mid-burst: eng_ready drops in the same cycle. The at-most-one in-flight registered beat is still written, which the 2-entry margin covers. Beat order is preserved.
- busy = (state==BURST).
- An engine whose eng_valid deasserts while not granted loses no state; the arbiter keeps no per-engine request memory.

Test Plan:
- After clear, engine 0 alone presents 7 beats D0..D6, last on D6, fifo_full=0 → grant one cycle after first valid; out_wr high 7 consecutive cycles starting 1 cycle after first accept; out_src=0; out_last only with D6; mb_count=1; len_err=0.
- Engines 0 and 1 both valid continuously for 3 bursts each → output order E0,E1,E0,E1,E0,E1; no beat interleaving; 1 idle cycle between bursts; mb_count=6.
- fifo_full rises on the cycle of beat 3 and holds 4 cycles → eng_ready[grant]=0 for those 4 cycles; beat 3 writes only after release; data sequence D0..D6 unchanged; total out_wr count 7.
- Engine 1 asserts eng_last on beat 4 → burst ends after 5 beats with out_last on beat 4; len_err=1 stays set. Next burst of 7 beats without eng_last → ends at beat 7; len_err remains 1; clear → len_err=0, mb_count=0.
- Engine 0 granted drops eng_valid for 3 cycles mid-burst while engine 1 is valid → eng_ready[1] stays 0; no engine-1 beat appears until engine 0's burst completes.
- Assert rst_n=0 during beat 2, then clear during beat 4 of a later burst → all outputs 0 immediately and state IDLE. After clear, the next grant goes to engine 0 even if engine 0 was granted last.

Source files
------------

// File: rtl/enc_out_arbiter.sv
// enc_out_arbiter: round-robin arbiter that gives the shared encoded-output FIFO
// write port to one macroblock engine at a time. Each result burst is forwarded
// whole, and the FIFO backpressure is passed to the engine that holds the grant.
//
// state | meaning
// IDLE  | no owner; choose the next requester round-robin (one bubble cycle)
// BURST | owner granted; forward its beats until the burst-end beat is accepted
module enc_out_arbiter #(
  parameter int N_ENG     = 2,
  parameter int DATA_W    = 1024,
  parameter int BURST_LEN = 7,
  parameter int SRC_W     = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic [N_ENG-1:0]        eng_valid,
  input  logic [N_ENG-1:0]        eng_last,
  input  logic [N_ENG*DATA_W-1:0] eng_data,
  output logic [N_ENG-1:0]        eng_ready,
  input  logic                    fifo_full,
  output logic                    out_wr,
  output logic [DATA_W-1:0]       out_data,
  output logic [SRC_W-1:0]        out_src,
  output logic                    out_last,
  output logic                    busy,
  output logic [15:0]             mb_count,
  output logic                    len_err
);

  localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BCW-1:0]   BEAT_MAX = BCW'(BURST_LEN - 1);
  localparam logic [SRC_W-1:0] SRC_TOP  = SRC_W'(N_ENG - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] last_grant;
  logic [BCW-1:0]   beat_cnt;

  logic [SRC_W-1:0]  pick;
  logic              pick_ok;
  logic [DATA_W-1:0] grant_data;
  logic              grant_valid;
  logic              grant_last;
  logic              accept;
  logic              cnt_at_max;
  logic              burst_end;
  logic              len_bad;

  // Round-robin pick: first requester at last_grant+1, +2, ... (mod N_ENG).
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    for (int k = 1; k <= N_ENG; k++) begin
      for (int i = 0; i < N_ENG; i++) begin
        if (!pick_ok && eng_valid[i] &&
            (((int'(last_grant) + k) % N_ENG) == i)) begin
          pick    = SRC_W'(i);
          pick_ok = 1'b1;
        end
      end
    end
  end

  // Route the granted engine's beat and handshake; ready is held off during clear
  // so no beat is consumed in a cycle whose result would be discarded.
  always_comb begin
    grant_data  = '0;
    grant_valid = 1'b0;
    grant_last  = 1'b0;
    eng_ready   = '0;
    for (int i = 0; i < N_ENG; i++) begin
      if (grant == SRC_W'(i)) begin
        grant_data   = eng_data[i*DATA_W +: DATA_W];
        grant_valid  = eng_valid[i];
        grant_last   = eng_last[i];
        eng_ready[i] = (state == BURST) && !fifo_full && !clear;
      end
    end
  end

  // Burst termination and length checking for the beat being accepted.
  always_comb begin
    accept     = (state == BURST) && grant_valid && !fifo_full && !clear;
    cnt_at_max = (beat_cnt == BEAT_MAX);
    burst_end  = accept && (grant_last || cnt_at_max);
    len_bad    = accept && (grant_last != cnt_at_max);
  end

  assign busy = (state == BURST);

  // Arbiter FSM with registered FIFO write port, burst counter and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SRC_TOP;
      beat_cnt   <= '0;
      out_wr     <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      out_last   <= 1'b0;
      mb_count   <= '0;
      len_err    <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= SRC_TOP;
      beat_cnt   <= '0;
      out_wr     <= 1'b0;
      out_data   <= '0;
      out_src    <= '0;
      out_last   <= 1'b0;
      mb_count   <= '0;
      len_err    <= 1'b0;
    end else begin
      out_wr   <= accept;
      out_last <= burst_end;
      if (accept) begin
        out_data <= grant_data;
        out_src  <= grant;
      end
      if (len_bad) begin
        len_err <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (pick_ok) begin
            grant    <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          if (accept) begin
            if (burst_end) begin
              last_grant <= grant;
              mb_count   <= mb_count + 16'd1;
              beat_cnt   <= '0;
              state      <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
